// File: rtl/ifu_mem_arb_pkg.sv
// ifu_mem_arb_pkg
//   Shared definitions for the instruction-memory arbiter: response-owner
//   encoding, default address/data widths and the starvation counter width.
//   Optional feature macro used by the arbiter files: IFU_ARB_STARVE_EN.
package ifu_mem_arb_pkg;

   localparam int INST_ADDR_WIDTH = 32;
   localparam int INST_DATA_WIDTH = 32;
   localparam int STARVE_CNT_W    = 4;   // holds STARVE_MAX up to 15

   // Who owns the memory word that returns in the next cycle.
   typedef enum logic [1:0] {
      ARB_OWN_NONE     = 2'd0,
      ARB_OWN_IFU      = 2'd1,
      ARB_OWN_LSU      = 2'd2,
      ARB_OWN_IFU_KILL = 2'd3
   } arb_own_e;

   // Owner of the response produced by this cycle's grant. A flush that
   // coincides with an IFU grant marks the fetch as killed so its word is
   // dropped when it returns.
   function automatic arb_own_e next_owner(input logic ifu_gnt,
                                           input logic lsu_gnt,
                                           input logic flush);
      arb_own_e own;
      own = ARB_OWN_NONE;
      if (ifu_gnt)
         own = flush ? ARB_OWN_IFU_KILL : ARB_OWN_IFU;
      else if (lsu_gnt)
         own = ARB_OWN_LSU;
      return own;
   endfunction

endpackage

// File: rtl/ifu_mem_arb_starve_cnt.sv
// ifu_arb_starve_cnt
//   Saturating count of consecutive cycles in which the IFU requested but was
//   not granted. Raises force_gnt once the count reaches STARVE_MAX while the
//   IFU is still requesting. Only built when IFU_ARB_STARVE_EN is defined.
// Ports:
//   clk       clock
//   rst       synchronous active-low reset
//   ifu_req   IFU fetch request
//   ifu_gnt   IFU granted this cycle
//   force_gnt IFU must win arbitration this cycle
`ifdef IFU_ARB_STARVE_EN
module ifu_arb_starve_cnt
   import ifu_mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic ifu_req,
   input  logic ifu_gnt,
   output logic force_gnt
);

   localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

   logic [STARVE_CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst)
         cnt <= '0;
      else if (!ifu_req || ifu_gnt)
         cnt <= '0;
      else if (cnt != CNT_MAX)
         cnt <= cnt + 1'b1;
   end

   assign force_gnt = ifu_req && (cnt == CNT_MAX);

endmodule
`endif

// File: rtl/ifu_mem_arb.sv
// ifu_mem_arb
//   Arbiter for the single-ported instruction memory shared by the IFU fetch
//   path and the LSU ROM read port. At most one read is granted per cycle and
//   the returned word is steered to the winner one cycle later. LSU has
//   priority; with IFU_ARB_STARVE_EN defined the IFU is force-granted after
//   STARVE_MAX consecutive denied cycles. A jump flush kills an in-flight or
//   just-granted IFU response; LSU traffic ignores the flush.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   ifu_req_i/ifu_addr_i          IFU fetch request and PC
//   ifu_gnt_o/ifu_rvalid_o/ifu_rdata_o   IFU grant, response valid, data
//   lsu_req_i/lsu_addr_i          LSU read request and address
//   lsu_gnt_o/lsu_rvalid_o/lsu_rdata_o   LSU grant, response valid, data
//   flush_i                       jump flush from ctrl
//   mem_req_o/mem_addr_o          memory read enable and address
//   mem_rdata_i                   memory data, valid the cycle after mem_req_o
//   hold_req_o                    IFU pending but blocked; ctrl stalls PC/IF-ID
module ifu_mem_arb
   import ifu_mem_arb_pkg::*;
#(
   parameter int ADDR_W     = INST_ADDR_WIDTH,
   parameter int DATA_W     = INST_DATA_WIDTH,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_i,
   input  logic [ADDR_W-1:0] ifu_addr_i,
   output logic              ifu_gnt_o,
   output logic              ifu_rvalid_o,
   output logic [DATA_W-1:0] ifu_rdata_o,
   input  logic              lsu_req_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   output logic              lsu_gnt_o,
   output logic              lsu_rvalid_o,
   output logic [DATA_W-1:0] lsu_rdata_o,
   input  logic              flush_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              hold_req_o
);

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_range
      $error("ifu_mem_arb: STARVE_MAX must be in 1..15");
   end

   logic     ifu_force;
   logic     ifu_gnt;
   logic     lsu_gnt;
   arb_own_e resp_own_p1;

`ifdef IFU_ARB_STARVE_EN
   ifu_arb_starve_cnt #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_cnt (
      .clk       (clk),
      .rst       (rst),
      .ifu_req   (ifu_req_i),
      .ifu_gnt   (ifu_gnt),
      .force_gnt (ifu_force)
   );
`else
   assign ifu_force = 1'b0;
`endif

   // ---- stage p0: combinational grant, address steering ----
   // rst gates every grant so nothing reaches memory while reset is held.
   assign ifu_gnt = rst && ifu_req_i && (!lsu_req_i || ifu_force);
   assign lsu_gnt = rst && lsu_req_i && !ifu_gnt;

   assign ifu_gnt_o  = ifu_gnt;
   assign lsu_gnt_o  = lsu_gnt;
   assign mem_req_o  = ifu_gnt | lsu_gnt;
   assign mem_addr_o = lsu_gnt ? lsu_addr_i : ifu_addr_i;
   assign hold_req_o = rst && ifu_req_i && !ifu_gnt && !flush_i;

   always_ff @(posedge clk) begin
      if (!rst)
         resp_own_p1 <= ARB_OWN_NONE;
      else
         resp_own_p1 <= next_owner(ifu_gnt, lsu_gnt, flush_i);
   end

   // ---- stage p1: response steering ----
   // A flush in the response cycle also drops the IFU word; rst gating
   // covers a reset arriving before the stale owner is cleared.
   assign ifu_rvalid_o = rst && (resp_own_p1 == ARB_OWN_IFU) && !flush_i;
   assign lsu_rvalid_o = rst && (resp_own_p1 == ARB_OWN_LSU);
   assign ifu_rdata_o  = mem_rdata_i;
   assign lsu_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_ifu_mem_arb.sv
module tb_ifu_mem_arb;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SMAX = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ifu_req;
   logic [AW-1:0] ifu_addr;
   logic          ifu_gnt;
   logic          ifu_rvalid;
   logic [DW-1:0] ifu_rdata;
   logic          lsu_req;
   logic [AW-1:0] lsu_addr;
   logic          lsu_gnt;
   logic          lsu_rvalid;
   logic [DW-1:0] lsu_rdata;
   logic          flush;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;
   logic          hold_req;

   always #5 clk = ~clk;

   ifu_mem_arb #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ifu_req_i    (ifu_req),
      .ifu_addr_i   (ifu_addr),
      .ifu_gnt_o    (ifu_gnt),
      .ifu_rvalid_o (ifu_rvalid),
      .ifu_rdata_o  (ifu_rdata),
      .lsu_req_i    (lsu_req),
      .lsu_addr_i   (lsu_addr),
      .lsu_gnt_o    (lsu_gnt),
      .lsu_rvalid_o (lsu_rvalid),
      .lsu_rdata_o  (lsu_rdata),
      .flush_i      (flush),
      .mem_req_o    (mem_req),
      .mem_addr_o   (mem_addr),
      .mem_rdata_i  (mem_rdata),
      .hold_req_o   (hold_req)
   );

   // Memory contents: a fixed scramble of the address.
   function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // Single-ported ROM with one cycle read latency.
   always @(posedge clk) begin
      if (mem_req)
         mem_rdata <= word_at(mem_addr);
   end

   int total = 0;
   int bad   = 0;

   // Reference model state: the response expected next cycle and the
   // number of consecutive cycles the IFU has been refused.
   bit            pend_v    = 1'b0;
   bit            pend_ifu  = 1'b0;
   bit            pend_kill = 1'b0;
   logic [AW-1:0] pend_addr = '0;
   int            denied    = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit iq, input logic [AW-1:0] ia,
                       input bit lq, input logic [AW-1:0] la, input bit fl);
      bit e_ig, e_lg, e_irv, e_lrv, e_hold, starved;
      logic [AW-1:0] e_addr;
      @(negedge clk);
      rst = r; ifu_req = iq; ifu_addr = ia; lsu_req = lq; lsu_addr = la; flush = fl;
      #1;
`ifdef IFU_ARB_STARVE_EN
      starved = iq && (denied >= SMAX);
`else
      starved = 1'b0;
`endif
      e_ig   = r && iq && (!lq || starved);
      e_lg   = r && lq && !e_ig;
      e_hold = r && iq && !e_ig && !fl;
      e_addr = e_lg ? la : ia;
      e_irv  = r && pend_v && pend_ifu && !pend_kill && !fl;
      e_lrv  = r && pend_v && !pend_ifu;

      chk("ifu_gnt",    64'(ifu_gnt),    64'(e_ig));
      chk("lsu_gnt",    64'(lsu_gnt),    64'(e_lg));
      chk("mem_req",    64'(mem_req),    64'(e_ig | e_lg));
      chk("hold_req",   64'(hold_req),   64'(e_hold));
      chk("ifu_rvalid", 64'(ifu_rvalid), 64'(e_irv));
      chk("lsu_rvalid", 64'(lsu_rvalid), 64'(e_lrv));
      if (e_ig | e_lg)
         chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      if (e_irv)
         chk("ifu_rdata", 64'(ifu_rdata), 64'(word_at(pend_addr)));
      if (e_lrv)
         chk("lsu_rdata", 64'(lsu_rdata), 64'(word_at(pend_addr)));

      pend_v    = e_ig | e_lg;
      pend_ifu  = e_ig;
      pend_kill = e_ig && fl;
      pend_addr = e_ig ? ia : la;
      if (!r || !iq || e_ig)
         denied = 0;
      else if (denied < SMAX)
         denied++;
   endtask

   initial begin
      rst = 1'b0; ifu_req = 1'b0; ifu_addr = '0;
      lsu_req = 1'b0; lsu_addr = '0; flush = 1'b0;

      // Reset with requests present: nothing may be granted.
      step(0, 1, 32'h0, 1, 32'h100, 0);
      step(0, 1, 32'h0, 0, 32'h0,   0);

      // IFU-only back-to-back fetches.
      step(1, 1, 32'h0, 0, 32'h0, 0);
      step(1, 1, 32'h4, 0, 32'h0, 0);
      step(1, 1, 32'h8, 0, 32'h0, 0);
      step(1, 0, 32'h0, 0, 32'h0, 0);

      // Both request: LSU wins, IFU granted once LSU drops.
      step(1, 1, 32'hC, 1, 32'h100, 0);
      step(1, 1, 32'hC, 0, 32'h0,   0);
      step(1, 0, 32'h0, 0, 32'h0,   0);

      // Continuous contention (starvation relief when enabled).
      for (int i = 0; i < 8; i++)
         step(1, 1, 32'h20, 1, 32'h200 + 32'(4 * i), 0);
      step(1, 0, 32'h0, 0, 32'h0, 0);

      // Flush in the response cycle, LSU granted alongside.
      step(1, 1, 32'h40, 0, 32'h0,   0);
      step(1, 0, 32'h0,  1, 32'h300, 1);
      step(1, 0, 32'h0,  0, 32'h0,   0);
      // Flush in the grant cycle, then LSU response with a flush present.
      step(1, 1, 32'h44, 0, 32'h0,   1);
      step(1, 0, 32'h0,  1, 32'h304, 0);
      step(1, 0, 32'h0,  0, 32'h0,   1);

      // Reset between an LSU grant and its response.
      step(1, 0, 32'h0,  1, 32'h400, 0);
      step(0, 1, 32'h50, 1, 32'h404, 0);
      step(1, 1, 32'h50, 1, 32'h408, 0);
      step(1, 1, 32'h54, 0, 32'h0,   0);
      step(1, 0, 32'h0,  0, 32'h0,   0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++)
         step(($urandom_range(39) != 0),
              ($urandom_range(1) == 1), {$urandom_range(16'hFFFF), 2'b00},
              ($urandom_range(1) == 1), {$urandom_range(16'hFFFF), 2'b00},
              ($urandom_range(5) == 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
